// File: rtl/cr_osf_ss_ctl_if.sv
// Handshake bundle between the OSF register block (master) and the
// single-step sequencer (slave).
interface cr_osf_ss_ctl_if #(
  parameter int STEP_W = 16
);
  logic [1:0]        fifo_debug_mode;
  logic              ss_cmd_valid;
  logic [STEP_W-1:0] ss_cmd_count;
  logic              ss_abort;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              single_step_rd;
  logic              ss_busy;
  logic              ss_done;
  logic [STEP_W-1:0] ss_remaining;
  logic [STEP_W-1:0] ss_steps_done;
  logic              ss_err;
  logic              ss_stall;

  modport master (
    output fifo_debug_mode, ss_cmd_valid, ss_cmd_count, ss_abort, fifo_empty, fifo_pop,
    input  single_step_rd, ss_busy, ss_done, ss_remaining, ss_steps_done, ss_err, ss_stall
  );

  modport slave (
    input  fifo_debug_mode, ss_cmd_valid, ss_cmd_count, ss_abort, fifo_empty, fifo_pop,
    output single_step_rd, ss_busy, ss_done, ss_remaining, ss_steps_done, ss_err, ss_stall
  );
endinterface

// File: rtl/cr_osf_ss_ctl.sv
// OSF single-step sequencer: releases one FIFO word per step through a
// registered single_step_rd gate, with gap, stall and abort handling.
module cr_osf_ss_ctl #(
  parameter int STEP_W  = 16,
  parameter int GAP_CYC = 2,
  parameter int TMO_W   = 12
) (
  input  logic            clk,
  input  logic            rst,
  cr_osf_ss_ctl_if.slave  bus
);
  localparam logic [1:0] MODE_SS  = 2'd3;
  localparam logic [3:0] GAP_INIT = 4'(GAP_CYC);

  typedef enum logic [2:0] {IDLE, ARM, STEP, GAP, DONE} state_t;

  state_t            state;
  logic [3:0]        gap_cnt;
  logic [TMO_W-1:0]  stall_cnt;
  logic [TMO_W-1:0]  stall_inc;
  logic              srd, busy, done, err, stall;
  logic [STEP_W-1:0] remaining, steps_done;
  logic              cmd_ok, stop, to_done;

  always_comb begin
    cmd_ok    = bus.ss_cmd_valid && (state == IDLE) &&
                (bus.ss_cmd_count != '0) && (bus.fifo_debug_mode == MODE_SS);
    // Leaving single-step mode while busy behaves exactly like an abort.
    stop      = bus.ss_abort || (bus.fifo_debug_mode != MODE_SS);
    stall_inc = stall_cnt + 1'b1;
    to_done   = 1'b0;
    case (state)
      ARM, GAP: to_done = stop;
      STEP:     to_done = stop || (bus.fifo_pop && (remaining == STEP_W'(1)));
      default:  to_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      stall_cnt  <= '0;
      srd        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      stall      <= 1'b0;
      remaining  <= '0;
      steps_done <= '0;
    end else begin
      done <= 1'b0;
      if (bus.ss_cmd_valid && !cmd_ok)
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (cmd_ok) begin
            remaining  <= bus.ss_cmd_count;
            steps_done <= '0;
            err        <= 1'b0;
            stall      <= 1'b0;
            busy       <= 1'b1;
            state      <= ARM;
          end
        end
        ARM: begin
          if (!stop && !bus.fifo_empty) begin
            state     <= STEP;
            srd       <= 1'b1;
            stall_cnt <= '0;
          end
        end
        STEP: begin
          // A pop is always counted, even when the sequence ends this cycle.
          if (bus.fifo_pop) begin
            remaining  <= remaining - STEP_W'(1);
            steps_done <= steps_done + STEP_W'(1);
            stall_cnt  <= '0;
          end else if (stall_cnt != '1) begin
            stall_cnt <= stall_inc;
            if (&stall_inc)
              stall <= 1'b1;
          end
          if (bus.fifo_pop && !to_done) begin
            state   <= GAP;
            gap_cnt <= GAP_INIT;
            srd     <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt <= 4'd1)
            state <= ARM;
          else
            gap_cnt <= gap_cnt - 4'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (to_done) begin
        state <= DONE;
        srd   <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

  assign bus.single_step_rd = srd;
  assign bus.ss_busy        = busy;
  assign bus.ss_done        = done;
  assign bus.ss_remaining   = remaining;
  assign bus.ss_steps_done  = steps_done;
  assign bus.ss_err         = err;
  assign bus.ss_stall       = stall;
endmodule

// File: tb/tb_cr_osf_ss_ctl.sv
// Directed bench for cr_osf_ss_ctl (GAP_CYC=2, TMO_W=4).
module tb_cr_osf_ss_ctl;
  localparam int STEP_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_ass  = 0;
  int   n_fail = 0;
  int   n;
  int   bad;

  cr_osf_ss_ctl_if #(.STEP_W(STEP_W)) bus();

  cr_osf_ss_ctl #(.STEP_W(STEP_W), .GAP_CYC(2), .TMO_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_ass++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [STEP_W-1:0] cnt);
    bus.ss_cmd_valid = 1'b1;
    bus.ss_cmd_count = cnt;
    step();
    bus.ss_cmd_valid = 1'b0;
  endtask

  task automatic pop();
    bus.fifo_pop = 1'b1;
    step();
    bus.fifo_pop = 1'b0;
  endtask

  // Cycles until single_step_rd rises, bounded.
  task automatic wait_srd(output int cyc);
    cyc = 0;
    while (!bus.single_step_rd && cyc < 30) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.fifo_debug_mode = 2'd3;
    bus.ss_cmd_valid    = 1'b0;
    bus.ss_cmd_count    = '0;
    bus.ss_abort        = 1'b0;
    bus.fifo_empty      = 1'b0;
    bus.fifo_pop        = 1'b0;
    repeat (2) step();
    chk("rst_srd",   bus.single_step_rd, 0);
    chk("rst_busy",  bus.ss_busy, 0);
    chk("rst_done",  bus.ss_done, 0);
    chk("rst_rem",   bus.ss_remaining, 0);
    chk("rst_steps", bus.ss_steps_done, 0);
    chk("rst_err",   bus.ss_err, 0);
    chk("rst_stall", bus.ss_stall, 0);
    rst = 1'b0;
    step();

    // Abort and pop in IDLE are ignored
    bus.ss_abort = 1'b1; bus.fifo_pop = 1'b1;
    step();
    bus.ss_abort = 1'b0; bus.fifo_pop = 1'b0;
    chk("idle_abort_done", bus.ss_done, 0);
    chk("idle_pop_steps", bus.ss_steps_done, 0);

    // Basic sequence, count=3
    cmd(3);
    chk("bas_busy", bus.ss_busy, 1);
    chk("bas_rem0", bus.ss_remaining, 3);
    chk("bas_arm_srd", bus.single_step_rd, 0);
    step();
    chk("bas_step_srd", bus.single_step_rd, 1);
    pop();
    chk("bas_pop1_srd", bus.single_step_rd, 0);
    chk("bas_pop1_rem", bus.ss_remaining, 2);
    chk("bas_pop1_steps", bus.ss_steps_done, 1);
    wait_srd(n);
    chk("bas_gap1", n, 3);
    pop();
    chk("bas_pop2_rem", bus.ss_remaining, 1);
    wait_srd(n);
    chk("bas_gap2", n, 3);
    pop();
    chk("bas_done", bus.ss_done, 1);
    chk("bas_done_busy", bus.ss_busy, 0);
    chk("bas_done_srd", bus.single_step_rd, 0);
    chk("bas_steps", bus.ss_steps_done, 3);
    chk("bas_rem", bus.ss_remaining, 0);
    step();
    chk("bas_done_pulse", bus.ss_done, 0);
    chk("bas_hold_steps", bus.ss_steps_done, 3);

    // Empty wait, count=2; a pop in ARM is ignored
    bus.fifo_empty = 1'b1;
    cmd(2);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.fifo_pop = (i == 5);
      step();
      if (bus.single_step_rd !== 1'b0 || bus.ss_busy !== 1'b1) bad++;
    end
    bus.fifo_pop = 1'b0;
    chk("emp_hold", bad, 0);
    chk("emp_arm_pop_rem", bus.ss_remaining, 2);
    bus.fifo_empty = 1'b0;
    step();
    chk("emp_step_srd", bus.single_step_rd, 1);
    pop();
    wait_srd(n);
    chk("emp_gap", n, 3);
    pop();
    chk("emp_done", bus.ss_done, 1);
    chk("emp_steps", bus.ss_steps_done, 2);
    step();

    // Illegal commands
    cmd(0);
    chk("ill_cnt0_err", bus.ss_err, 1);
    chk("ill_cnt0_busy", bus.ss_busy, 0);
    cmd(1);
    chk("ill_ok_err", bus.ss_err, 0);
    chk("ill_ok_busy", bus.ss_busy, 1);
    step();
    cmd(5);
    chk("ill_busy_err", bus.ss_err, 1);
    chk("ill_busy_srd", bus.single_step_rd, 1);
    chk("ill_busy_rem", bus.ss_remaining, 1);
    pop();
    chk("ill_busy_done", bus.ss_done, 1);
    chk("ill_busy_steps", bus.ss_steps_done, 1);
    chk("ill_busy_err_hold", bus.ss_err, 1);
    step();
    cmd(1);
    chk("ill_ok2_err", bus.ss_err, 0);
    step();
    pop();
    step();
    bus.fifo_debug_mode = 2'd0;
    cmd(1);
    chk("ill_mode_err", bus.ss_err, 1);
    chk("ill_mode_busy", bus.ss_busy, 0);
    bus.fifo_debug_mode = 2'd3;
    step();

    // Abort colliding with the 2nd pop, count=5
    cmd(5);
    step();
    pop();
    wait_srd(n);
    chk("abt_gap", n, 3);
    bus.ss_abort = 1'b1;
    pop();
    bus.ss_abort = 1'b0;
    chk("abt_done", bus.ss_done, 1);
    chk("abt_steps", bus.ss_steps_done, 2);
    chk("abt_rem", bus.ss_remaining, 3);
    chk("abt_srd", bus.single_step_rd, 0);
    step();
    chk("abt_done_pulse", bus.ss_done, 0);
    chk("abt_idle_busy", bus.ss_busy, 0);
    step();
    chk("abt_no_repulse", bus.ss_done, 0);

    // Stall timeout (TMO_W=4) then mode drop
    cmd(1);
    step();
    repeat (14) step();
    chk("stl_pre", bus.ss_stall, 0);
    step();
    chk("stl_set", bus.ss_stall, 1);
    repeat (3) step();
    chk("stl_still_step", bus.single_step_rd, 1);
    chk("stl_still_busy", bus.ss_busy, 1);
    bus.fifo_debug_mode = 2'd2;
    step();
    chk("mdr_done", bus.ss_done, 1);
    chk("mdr_srd", bus.single_step_rd, 0);
    chk("mdr_err", bus.ss_err, 0);
    step();
    chk("mdr_idle_done", bus.ss_done, 0);
    chk("mdr_idle_busy", bus.ss_busy, 0);
    chk("mdr_stall_sticky", bus.ss_stall, 1);
    bus.fifo_debug_mode = 2'd3;
    step();

    // Reset during GAP of a count=4 sequence
    cmd(4);
    step();
    pop();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rsm_srd",   bus.single_step_rd, 0);
    chk("rsm_busy",  bus.ss_busy, 0);
    chk("rsm_done",  bus.ss_done, 0);
    chk("rsm_rem",   bus.ss_remaining, 0);
    chk("rsm_steps", bus.ss_steps_done, 0);
    chk("rsm_stall", bus.ss_stall, 0);
    step();
    chk("rsm_no_done", bus.ss_done, 0);
    cmd(1);
    chk("rsm_new_busy", bus.ss_busy, 1);
    step();
    pop();
    chk("rsm_new_done", bus.ss_done, 1);
    chk("rsm_new_steps", bus.ss_steps_done, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_ass, n_fail);
    $finish;
  end
endmodule
